mem_delayed_ctrl: RTL and testbench
===================================

Name: mem_delayed_ctrl

Overview:
- Memory-side partner of the processor's memory port. Accepts single-cycle read and write request pulses and serves them from an internal word array after a fixed, configurable latency.
- Signals completion with a one-cycle ack and holds read data until the next read completes.
- Gives the processor's C1/C2 wait states a realistic multi-cycle memory to exercise in simulation and on small FPGA builds.

Parameters:
ADDR_WIDTH, 32, byte-address width; matches processor mem_addr
DATA_WIDTH, 32, word width; matches processor mem_rd_data/mem_wr_data
DEPTH, 4096, number of DATA_WIDTH words in the backing array
LATENCY, 5, cycles from request to ack; legal range 1..255

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
mem_addr  input  ADDR_WIDTH  byte address; sampled only in the request cycle
mem_rd_req  input  1  read request pulse
mem_wr_req  input  1  write request pulse
mem_wr_data  input  DATA_WIDTH  write data; sampled only in the request cycle
mem_rd_data  output  DATA_WIDTH  read data; registered, held between reads
mem_ack  output  1  one-cycle completion pulse
mem_busy  output  1  high while a request is outstanding
ld_en  input  1  testbench/boot loader write enable; bypasses latency
ld_addr  input  ADDR_WIDTH  loader byte address
ld_data  input  DATA_WIDTH  loader data

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: mem_rd_data=0, mem_ack=0, mem_busy=0, state=IDLE, counter=0.
- Reset does not clear the array. Reset during BUSY aborts the access: no ack, no array write.
- Addressing: word index = addr[ADDR_WIDTH-1:2]. addr[1:0] are ignored; no misalignment fault.
- Out of range (index >= DEPTH): reads return 0, writes are dropped. Ack timing is unchanged.
- FSM states: IDLE and BUSY.
- IDLE -> BUSY when mem_rd_req|mem_wr_req is sampled high:
  - latch addr, wr_data and op;
  - load counter = LATENCY-1;
  - mem_busy=1 from the next cycle.
- BUSY: counter decrements by 1 each cycle. The cycle after counter==0 is observed, the block performs the access:
  - mem_ack=1 for exactly that cycle;
  - on a read, mem_rd_data is updated in that same cycle;
  - mem_busy=0 in that same cycle;
  - state returns to IDLE.
- Timing: a request in cycle N produces ack in cycle N+LATENCY. With LATENCY=1, ack arrives in cycle N+1.
- The ack cycle is IDLE, so a new request in the ack cycle is accepted. Back-to-back throughput is one access per LATENCY cycles.
- A request while BUSY (excluding the ack cycle) is ignored: no queueing, no second ack.
- mem_rd_req and mem_wr_req both high in the same cycle: treated as a write; mem_rd_data is not updated.
- Write completion leaves mem_rd_data unchanged.
- Loader port:
  - ld_en writes array[ld_addr index] at the clock edge, independent of FSM state.
  - If a completing processor write targets the same word in the same cycle, the processor write wins.
  - Loader writes during rst are honoured.
  - A completing read returns the array value before any same-cycle loader write (read-before-write).

Optional Feature:
MEM_DELAYED_CTRL_ERR_EN
- Defined:
  - adds output port mem_err (1 bit, reset 0);
  - mem_err is sticky and cleared only by rst;
  - it is set the cycle after a request arrives while BUSY (excluding the ack cycle), when rd and wr are asserted together, or when an accepted request is out of range.
  - Each event also issues a $display with the time and address.
- Undefined: the port is absent and all of these events are silent. Functional behaviour is otherwise identical.

Test Plan:
- LATENCY=5: write 0xDEADBEEF to addr 0x40 in cycle 10 -> mem_busy high cycles 11-14, mem_ack in cycle 15 only; read 0x40 in cycle 15 -> ack cycle 20, mem_rd_data=0xDEADBEEF, held through cycle 30.
- LATENCY=1: preload words 0..3 = 1,2,3,4 via loader; four back-to-back reads of 0x0,0x4,0x8,0xC each issued in the prior ack cycle -> acks in consecutive cycles with data 1,2,3,4.
- Read issued at cycle 10; second read to 0x8 at cycle 12 (busy) -> single ack at cycle 15 carrying the first address's data; with ERR_EN, mem_err=1 from cycle 13.
- Addr 0x3 read after loader wrote 0x55 to 0x0 -> returns 0x55 (low bits ignored); read of index DEPTH (0x4000) -> ack on time, data 0; write there leaves array unchanged.
- Read accepted at cycle 10, rst high in cycle 12 -> no ack ever; mem_busy=0, mem_rd_data=0 after reset; previously loaded array contents still readable.
- rd and wr asserted together, addr 0x20, data 7 -> acts as write: mem_rd_data unchanged at ack; a later read of 0x20 returns 7; with ERR_EN, mem_err=1.

Source files
------------

// File: rtl/mem_delayed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_delayed_ctrl
// Description : Word-array memory with a fixed request-to-ack latency. It
//               accepts one read/write pulse at a time and acks it LATENCY
//               cycles later. A loader port writes the array directly,
//               without going through the latency path.
//               Optional build macro MEM_DELAYED_CTRL_ERR_EN adds a sticky
//               mem_err output for protocol and range violations.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_delayed_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096,
  parameter int LATENCY    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_req,
  input  logic                  mem_wr_req,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_ack,
  output logic                  mem_busy,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data
`ifdef MEM_DELAYED_CTRL_ERR_EN
  ,
  output logic                  mem_err
`endif
);

  localparam int c_IDX_W = ADDR_WIDTH - 2;
  localparam int c_ARR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_IDX_W:0] c_DEPTH = (c_IDX_W + 1)'(DEPTH);
  localparam logic [7:0] c_LOAD = 8'(LATENCY - 1);
  // With a latency of one the access completes at the accepting edge itself,
  // so the FSM never enters BUSY and the request inputs feed the array path.
  localparam bit c_IMMEDIATE = (LATENCY == 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t                r_state;
  logic [7:0]            r_count;
  logic [c_IDX_W-1:0]    r_idx;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_op_wr;
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  logic                  w_req;
  logic                  w_accept;
  logic [c_IDX_W-1:0]    w_req_idx;
  logic [c_IDX_W-1:0]    w_ld_idx;
  logic                  w_ld_in_range;
  logic                  w_done;
  logic [c_IDX_W-1:0]    w_done_idx;
  logic                  w_done_wr;
  logic [DATA_WIDTH-1:0] w_done_data;
  logic                  w_done_in_range;
  logic [c_ARR_W-1:0]    w_done_arr;
  logic                  w_unused;

  assign w_req     = mem_rd_req | mem_wr_req;
  assign w_accept  = (r_state == S_IDLE) && w_req && !rst;
  assign w_req_idx = mem_addr[ADDR_WIDTH-1:2];
  assign w_ld_idx  = ld_addr[ADDR_WIDTH-1:2];
  assign w_ld_in_range = ({1'b0, w_ld_idx} < c_DEPTH);

  // Completion happens at the edge ending the last BUSY cycle, so the ack is
  // visible exactly LATENCY cycles after the request cycle.
  assign w_done      = c_IMMEDIATE ? w_accept
                                   : ((r_state == S_BUSY) && (r_count == 8'd1) && !rst);
  assign w_done_idx  = c_IMMEDIATE ? w_req_idx : r_idx;
  assign w_done_wr   = c_IMMEDIATE ? mem_wr_req : r_op_wr;
  assign w_done_data = c_IMMEDIATE ? mem_wr_data : r_wr_data;
  assign w_done_in_range = ({1'b0, w_done_idx} < c_DEPTH);
  assign w_done_arr  = w_done_idx[c_ARR_W-1:0];

  // Byte-offset bits carry no meaning for a word-addressed array.
  assign w_unused = ^{mem_addr[1:0], ld_addr[1:0]};

  // Request FSM: accept in IDLE, count down in BUSY, complete with a one-cycle ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= 8'd0;
      r_idx       <= '0;
      r_wr_data   <= '0;
      r_op_wr     <= 1'b0;
      mem_ack     <= 1'b0;
      mem_busy    <= 1'b0;
      mem_rd_data <= '0;
    end else begin
      mem_ack <= w_done;
      if (w_done) begin
        r_state  <= S_IDLE;
        r_count  <= 8'd0;
        mem_busy <= 1'b0;
        // Reads sample the array before any same-edge loader write lands.
        if (!w_done_wr) begin
          mem_rd_data <= w_done_in_range ? r_mem[w_done_arr] : '0;
        end
      end else if (r_state == S_BUSY) begin
        r_count <= r_count - 8'd1;
      end else if (w_accept) begin
        r_state   <= S_BUSY;
        r_count   <= c_LOAD;
        mem_busy  <= 1'b1;
        r_idx     <= w_req_idx;
        r_wr_data <= mem_wr_data;
        // Simultaneous read and write requests are serviced as a write.
        r_op_wr   <= mem_wr_req;
      end
    end
  end

  // Backing array: loader first, so a completing processor write to the same word overrides it.
  always_ff @(posedge clk) begin
    if (ld_en && w_ld_in_range) begin
      r_mem[w_ld_idx[c_ARR_W-1:0]] <= ld_data;
    end
    if (w_done && w_done_wr && w_done_in_range) begin
      r_mem[w_done_arr] <= w_done_data;
    end
  end

`ifdef MEM_DELAYED_CTRL_ERR_EN
  logic r_err;
  logic w_err_busy;
  logic w_err_both;
  logic w_err_range;
  logic w_err_any;

  // A request in the completing BUSY cycle is still dropped, so it counts too.
  assign w_err_busy  = (r_state == S_BUSY) && w_req;
  assign w_err_both  = mem_rd_req && mem_wr_req;
  assign w_err_range = w_accept && !({1'b0, w_req_idx} < c_DEPTH);
  assign w_err_any   = !rst && (w_err_busy || w_err_both || w_err_range);
  assign mem_err     = r_err;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_err_any) begin
      r_err <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Simulation trace of each protocol event.
  always_ff @(posedge clk) begin
    if (w_err_any) begin
      $display("[%0t] mem_delayed_ctrl: protocol event at addr 0x%0h (busy=%0b both=%0b range=%0b)",
               $time, mem_addr, w_err_busy, w_err_both, w_err_range);
    end
  end
`endif
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_delayed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_delayed_ctrl
// Description : Self-checking bench for mem_delayed_ctrl. One instance runs at
//               LATENCY=5, a second at LATENCY=1. A word-array reference model
//               predicts read data and ack timing from the request cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_delayed_ctrl;

  localparam int DEPTH = 4096;
  localparam int LA    = 5;
  localparam int LB    = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a_addr, a_wdata, a_rdata, a_ld_addr, a_ld_data;
  logic        a_rd, a_wr, a_ack, a_busy, a_ld_en;
  logic [31:0] b_addr, b_wdata, b_rdata, b_ld_addr, b_ld_data;
  logic        b_rd, b_wr, b_ack, b_busy, b_ld_en;
`ifdef MEM_DELAYED_CTRL_ERR_EN
  logic        a_err, b_err;
`endif

  mem_delayed_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LA)) u_dut_a (
    .clk(clk), .rst(rst), .mem_addr(a_addr), .mem_rd_req(a_rd), .mem_wr_req(a_wr),
    .mem_wr_data(a_wdata), .mem_rd_data(a_rdata), .mem_ack(a_ack), .mem_busy(a_busy),
    .ld_en(a_ld_en), .ld_addr(a_ld_addr), .ld_data(a_ld_data)
`ifdef MEM_DELAYED_CTRL_ERR_EN
    , .mem_err(a_err)
`endif
  );

  mem_delayed_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH), .LATENCY(LB)) u_dut_b (
    .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_rd_req(b_rd), .mem_wr_req(b_wr),
    .mem_wr_data(b_wdata), .mem_rd_data(b_rdata), .mem_ack(b_ack), .mem_busy(b_busy),
    .ld_en(b_ld_en), .ld_addr(b_ld_addr), .ld_data(b_ld_data)
`ifdef MEM_DELAYED_CTRL_ERR_EN
    , .mem_err(b_err)
`endif
  );

  int vectors = 0;
  int errors  = 0;

  logic [31:0] model_a [0:DEPTH-1];
  logic [31:0] model_b [0:DEPTH-1];
  logic [31:0] exp_a, exp_b;

  function automatic bit in_range(input logic [31:0] addr);
    return (addr >> 2) < DEPTH;
  endfunction

  function automatic logic [31:0] ref_read_a(input logic [31:0] addr);
    return in_range(addr) ? model_a[addr[13:2]] : 32'h0;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_rd = 0; a_wr = 0; a_addr = 0; a_wdata = 0; a_ld_en = 0; a_ld_addr = 0; a_ld_data = 0;
    b_rd = 0; b_wr = 0; b_addr = 0; b_wdata = 0; b_ld_en = 0; b_ld_addr = 0; b_ld_data = 0;
    tick;
    // Loader writes are honoured while reset is held.
    for (int i = 0; i < 32; i++) begin
      a_ld_en = 1'b1; a_ld_addr = 32'(i * 4); a_ld_data = $urandom;
      model_a[i] = a_ld_data;
      tick;
    end
    a_ld_en = 1'b0;
    tick;
    exp_a = 32'h0; exp_b = 32'h0;
    vectors++;
    if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_a: busy/ack/rdata got %b/%b/%h want 0/0/0", a_busy, a_ack, a_rdata);
    end
    vectors++;
    if ({b_busy, b_ack, b_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL reset_b: busy/ack/rdata got %b/%b/%h want 0/0/0", b_busy, b_ack, b_rdata);
    end
`ifdef MEM_DELAYED_CTRL_ERR_EN
    vectors++;
    if ({a_err, b_err} !== 2'b00) begin
      errors++; $display("FAIL reset_err: got %b want 00", {a_err, b_err});
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_random_a;
    for (int i = 0; i < 24; i++) begin
      logic        w;
      logic [31:0] addr, data;
      w    = 1'($urandom_range(0, 1));
      addr = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      data = $urandom;
      a_addr = addr; a_wdata = data; a_rd = !w; a_wr = w;
      tick;
      // Address/data are sampled only in the request cycle.
      a_rd = 0; a_wr = 0; a_addr = $urandom; a_wdata = $urandom;
      for (int k = 1; k < LA; k++) begin
        vectors++;
        if ({a_busy, a_ack, a_rdata} !== {1'b1, 1'b0, exp_a}) begin
          errors++; $display("FAIL rand_busy[%0d,%0d]: busy/ack/rdata got %b/%b/%h want 1/0/%h", i, k, a_busy, a_ack, a_rdata, exp_a);
        end
        tick;
      end
      if (w) model_a[addr[13:2]] = data;
      else   exp_a = ref_read_a(addr);
      vectors++;
      if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b1, exp_a}) begin
        errors++; $display("FAIL rand_ack[%0d]: busy/ack/rdata got %b/%b/%h want 0/1/%h", i, a_busy, a_ack, a_rdata, exp_a);
      end
      repeat ($urandom_range(0, 2)) begin
        tick;
        vectors++;
        if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b0, exp_a}) begin
          errors++; $display("FAIL rand_hold[%0d]: busy/ack/rdata got %b/%b/%h want 0/0/%h", i, a_busy, a_ack, a_rdata, exp_a);
        end
      end
    end
    tick;
  endtask

  task automatic test_back_to_back_b;
    for (int i = 0; i < 4; i++) begin
      b_ld_en = 1'b1; b_ld_addr = 32'(i * 4); b_ld_data = 32'(i + 1);
      model_b[i] = b_ld_data;
      tick;
    end
    b_ld_en = 1'b0;
    // Directed reads, each issued in the previous ack cycle.
    for (int i = 0; i < 4; i++) begin
      b_addr = 32'(i * 4); b_rd = 1'b1;
      tick;
      exp_b = 32'(i + 1);
      vectors++;
      if ({b_busy, b_ack, b_rdata} !== {1'b0, 1'b1, exp_b}) begin
        errors++; $display("FAIL b2b_read[%0d]: busy/ack/rdata got %b/%b/%h want 0/1/%h", i, b_busy, b_ack, b_rdata, exp_b);
      end
    end
    // Random back-to-back mix at one access per cycle.
    for (int i = 0; i < 16; i++) begin
      logic        w;
      logic [31:0] addr, data;
      w = 1'($urandom_range(0, 1));
      addr = {28'h0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      data = $urandom;
      b_addr = addr; b_wdata = data; b_rd = !w; b_wr = w;
      tick;
      if (w) model_b[addr[13:2]] = data;
      else   exp_b = model_b[addr[13:2]];
      vectors++;
      if ({b_busy, b_ack, b_rdata} !== {1'b0, 1'b1, exp_b}) begin
        errors++; $display("FAIL b2b_rand[%0d]: busy/ack/rdata got %b/%b/%h want 0/1/%h", i, b_busy, b_ack, b_rdata, exp_b);
      end
    end
    b_rd = 0; b_wr = 0;
    tick;
    vectors++;
    if ({b_busy, b_ack, b_rdata} !== {1'b0, 1'b0, exp_b}) begin
      errors++; $display("FAIL b2b_idle: busy/ack/rdata got %b/%b/%h want 0/0/%h", b_busy, b_ack, b_rdata, exp_b);
    end
  endtask

  task automatic test_busy_ignore;
    a_addr = 32'h14; a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    for (int k = 1; k < LA; k++) begin
      vectors++;
      if ({a_busy, a_ack} !== 2'b10) begin
        errors++; $display("FAIL ignore_busy[%0d]: busy/ack got %b/%b want 1/0", k, a_busy, a_ack);
      end
`ifdef MEM_DELAYED_CTRL_ERR_EN
      vectors++;
      if (a_err !== (k >= 3)) begin
        errors++; $display("FAIL ignore_err[%0d]: got %b want %b", k, a_err, (k >= 3));
      end
`endif
      if (k == 2) begin a_addr = 32'h8; a_rd = 1'b1; end
      tick;
      a_rd = 1'b0;
    end
    exp_a = model_a[5];
    vectors++;
    if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b1, exp_a}) begin
      errors++; $display("FAIL ignore_ack: busy/ack/rdata got %b/%b/%h want 0/1/%h", a_busy, a_ack, a_rdata, exp_a);
    end
    for (int k = 0; k < 6; k++) begin
      tick;
      vectors++;
      if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b0, exp_a}) begin
        errors++; $display("FAIL ignore_noack[%0d]: busy/ack/rdata got %b/%b/%h want 0/0/%h", k, a_busy, a_ack, a_rdata, exp_a);
      end
    end
  endtask

  task automatic test_addressing;
    logic [31:0] t_addr [0:4];
    logic [31:0] t_data [0:4];
    logic        t_wr   [0:4];
    t_addr = '{32'h3, 32'h4000, 32'h4000, 32'h0, 32'h4002};
    t_data = '{32'h0, 32'h0, 32'hAAAA5555, 32'h0, 32'h0};
    t_wr   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    a_ld_en = 1'b1; a_ld_addr = 32'h0; a_ld_data = 32'h55; model_a[0] = 32'h55;
    tick;
    a_ld_en = 1'b0;
    for (int t = 0; t < 5; t++) begin
      a_addr = t_addr[t]; a_wdata = t_data[t]; a_rd = !t_wr[t]; a_wr = t_wr[t];
      tick;
      a_rd = 0; a_wr = 0;
      for (int k = 1; k < LA; k++) begin
        vectors++;
        if ({a_busy, a_ack} !== 2'b10) begin
          errors++; $display("FAIL addr_busy[%0d,%0d]: busy/ack got %b/%b want 1/0", t, k, a_busy, a_ack);
        end
        tick;
      end
      if (t_wr[t]) begin
        if (in_range(t_addr[t])) model_a[t_addr[t][13:2]] = t_data[t];
      end else begin
        exp_a = ref_read_a(t_addr[t]);
      end
      vectors++;
      if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b1, exp_a}) begin
        errors++; $display("FAIL addr_ack[%0d]: busy/ack/rdata got %b/%b/%h want 0/1/%h", t, a_busy, a_ack, a_rdata, exp_a);
      end
    end
    tick;
  endtask

  task automatic test_reset_abort;
    a_ld_en = 1'b1; a_ld_addr = 32'h24; a_ld_data = 32'h99; model_a[9] = 32'h99;
    tick;
    a_ld_en = 1'b0;
    a_addr = 32'h24; a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    repeat (LA - 1) tick;
    exp_a = 32'h99;
    vectors++;
    if ({a_ack, a_rdata} !== {1'b1, exp_a}) begin
      errors++; $display("FAIL abort_pre: ack/rdata got %b/%h want 1/%h", a_ack, a_rdata, exp_a);
    end
    // Abort a read, then a write to word 9; neither may complete.
    for (int t = 0; t < 2; t++) begin
      a_addr = 32'h24; a_wdata = 32'hBAD; a_rd = (t == 0); a_wr = (t == 1);
      tick;
      a_rd = 0; a_wr = 0;
      vectors++;
      if (a_busy !== 1'b1) begin
        errors++; $display("FAIL abort_busy[%0d]: got %b want 1", t, a_busy);
      end
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      exp_a = 32'h0;
      for (int k = 0; k < 8; k++) begin
        vectors++;
        if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b0, 32'h0}) begin
          errors++; $display("FAIL abort_idle[%0d,%0d]: busy/ack/rdata got %b/%b/%h want 0/0/0", t, k, a_busy, a_ack, a_rdata);
        end
`ifdef MEM_DELAYED_CTRL_ERR_EN
        vectors++;
        if (a_err !== 1'b0) begin
          errors++; $display("FAIL abort_err[%0d,%0d]: got %b want 0", t, k, a_err);
        end
`endif
        tick;
      end
    end
    a_addr = 32'h24; a_rd = 1'b1;
    tick;
    a_rd = 1'b0;
    repeat (LA - 1) tick;
    exp_a = model_a[9];
    vectors++;
    if ({a_ack, a_rdata} !== {1'b1, exp_a}) begin
      errors++; $display("FAIL abort_post: ack/rdata got %b/%h want 1/%h", a_ack, a_rdata, exp_a);
    end
    tick;
  endtask

  task automatic test_rd_wr_both;
    a_ld_en = 1'b1; a_ld_addr = 32'hC; a_ld_data = 32'h33; model_a[3] = 32'h33;
    tick;
    a_ld_en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      // t0: read word 3; t1: rd+wr to 0x20 (acts as write); t2: read 0x20
      a_addr = (t == 0) ? 32'hC : 32'h20; a_wdata = 32'h7;
      a_rd = 1'b1; a_wr = (t == 1);
      tick;
      a_rd = 0; a_wr = 0;
      repeat (LA - 1) tick;
      if (t == 1) model_a[8] = 32'h7;
      else        exp_a = ref_read_a((t == 0) ? 32'hC : 32'h20);
      vectors++;
      if ({a_busy, a_ack, a_rdata} !== {1'b0, 1'b1, exp_a}) begin
        errors++; $display("FAIL both_ack[%0d]: busy/ack/rdata got %b/%b/%h want 0/1/%h", t, a_busy, a_ack, a_rdata, exp_a);
      end
`ifdef MEM_DELAYED_CTRL_ERR_EN
      vectors++;
      if (a_err !== (t >= 1)) begin
        errors++; $display("FAIL both_err[%0d]: got %b want %b", t, a_err, (t >= 1));
      end
`endif
    end
    tick;
  endtask

  task automatic test_loader_collision;
    // Rows: processor write with loader hit on same word, read with loader hit, plain read.
    for (int t = 0; t < 3; t++) begin
      logic [31:0] pdata, ldata;
      pdata = $urandom; ldata = $urandom;
      a_addr = 32'h28; a_wdata = pdata; a_rd = (t != 0); a_wr = (t == 0);
      tick;
      a_rd = 0; a_wr = 0;
      for (int k = 1; k < LA; k++) begin
        if (k == LA - 1 && t < 2) begin
          a_ld_en = 1'b1; a_ld_addr = 32'h28; a_ld_data = ldata;
        end
        tick;
        a_ld_en = 1'b0;
      end
      if (t == 0) begin
        model_a[10] = pdata;
      end else begin
        exp_a = model_a[10];
        if (t == 1) model_a[10] = ldata;
      end
      vectors++;
      if ({a_ack, a_rdata} !== {1'b1, exp_a}) begin
        errors++; $display("FAIL collide[%0d]: ack/rdata got %b/%h want 1/%h", t, a_ack, a_rdata, exp_a);
      end
    end
  endtask

  initial begin
    test_reset;
    test_random_a;
    test_back_to_back_b;
    test_busy_ignore;
    test_addressing;
    test_reset_abort;
    test_rd_wr_both;
    test_loader_collision;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
